// File: rtl/product_writer_pkg.sv
// product_writer_pkg
// Shared constants and the FSM state encoding used by the product writer
// and its checker sub-module.
//   DW    : operand width (products are 2*DW wide)
//   AW    : result BRAM address width
//   DEPTH : operand entries in one sweep (addresses 0..DEPTH-1)
package product_writer_pkg;

    localparam int DW    = 16;
    localparam int AW    = 3;
    localparam int DEPTH = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/product_writer_checker.sv
// product_checker
// Registered compare of each stage-1 product against its behavioural gold
// value. Counts mismatches (saturating) and remembers the address of the
// first mismatch of the sweep.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clear     : start of a new sweep, zeroes the count and address
//   s1_v      : stage-1 entry is valid this cycle
//   s1_addr   : address of the stage-1 entry
//   s1_prod   : product produced by the multiplier
//   s1_gold   : reference product a*b
//   hit       : combinational, this cycle's entry mismatches
//   err_cnt   : mismatches so far in this sweep
//   err_addr  : address of the first mismatch
module product_checker #(
    parameter int DW = product_writer_pkg::DW,
    parameter int AW = product_writer_pkg::AW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            s1_v,
    input  logic [AW-1:0]   s1_addr,
    input  logic [2*DW-1:0] s1_prod,
    input  logic [2*DW-1:0] s1_gold,
    output logic            hit,
    output logic [AW:0]     err_cnt,
    output logic [AW-1:0]   err_addr
);

    logic [AW:0]   err_cnt_q, err_cnt_d;
    logic [AW-1:0] err_addr_q, err_addr_d;

    assign hit      = s1_v && (s1_prod != s1_gold);
    assign err_cnt  = err_cnt_q;
    assign err_addr = err_addr_q;

    // The first mismatch is recognised by the count still being zero,
    // so the address is latched exactly once per sweep.
    always_comb begin
        err_cnt_d  = err_cnt_q;
        err_addr_d = err_addr_q;
        if (clear) begin
            err_cnt_d  = '0;
            err_addr_d = '0;
        end else if (hit) begin
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
            if (err_cnt_q == '0) begin
                err_addr_d = s1_addr;
            end
        end
    end

    // Error state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q  <= '0;
            err_addr_q <= '0;
        end else begin
            err_cnt_q  <= err_cnt_d;
            err_addr_q <= err_addr_d;
        end
    end

endmodule

// File: rtl/product_writer.sv
// product_writer
// Captures each multiplier product with the address its operands came from,
// writes it into the result BRAM (port B) at that address, and checks it
// against a behavioural a*b. After DEPTH writes the sweep is flagged done
// with a pass/fail verdict.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start_stop   : run enable shared with the operand controller
//   a, b, addra  : operands and their source address (valid when v0=1)
//   product      : combinational multiplier output for a/b
//   enb, web     : BRAM enable (always 1) and write strobe
//   addrb, dinb  : BRAM write address and data
//   done, pass   : sweep complete / no mismatch in the sweep
//   err_cnt      : saturating mismatch count for the sweep
//   err_addr     : address of the first mismatch
module product_writer #(
    parameter int DW    = product_writer_pkg::DW,
    parameter int AW    = product_writer_pkg::AW,
    parameter int DEPTH = product_writer_pkg::DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_stop,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    input  logic [AW-1:0]   addra,
    input  logic [2*DW-1:0] product,
    output logic            enb,
    output logic            web,
    output logic [AW-1:0]   addrb,
    output logic [2*DW-1:0] dinb,
    output logic            done,
    output logic            pass,
    output logic [AW:0]     err_cnt,
    output logic [AW-1:0]   err_addr
);

    import product_writer_pkg::*;

    localparam logic [AW:0] LAST_WR = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] FULL_WR = (AW+1)'(DEPTH);

    state_e            state_q, state_d;
    logic              v0_q, v0_d;
    logic              s1_v_q, s1_v_d;
    logic [AW-1:0]     s1_addr_q, s1_addr_d;
    logic [2*DW-1:0]   s1_prod_q, s1_prod_d;
    logic [2*DW-1:0]   s1_gold_q, s1_gold_d;
    logic              web_q, web_d;
    logic [AW-1:0]     addrb_q, addrb_d;
    logic [2*DW-1:0]   dinb_q, dinb_d;
    logic [AW:0]       wr_cnt_q, wr_cnt_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              clear;
    logic              capture;
    logic              hit;

    assign enb   = 1'b1;
    assign web   = web_q;
    assign addrb = addrb_q;
    assign dinb  = dinb_q;
    assign done  = done_q;
    assign pass  = pass_q;

    // Sweep FSM plus write counter. The DEPTH-th write takes priority over a
    // simultaneous start_stop drop. A drop only returns to IDLE once both
    // v0 and stage 1 are empty, so the in-flight operand is still written.
    // Stage 1 captures only while the FSM stays in RUN, which keeps the
    // operand arriving alongside the final write out of the BRAM.
    always_comb begin
        state_d = state_q;
        wr_cnt_d = wr_cnt_q;
        done_d = done_q;
        pass_d = pass_q;
        clear = 1'b0;
        if (s1_v_q && (wr_cnt_q != FULL_WR)) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (start_stop) begin
                    state_d  = RUN;
                    clear    = 1'b1;
                    wr_cnt_d = '0;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
                end
            end
            RUN: begin
                if (s1_v_q && (wr_cnt_q == LAST_WR)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    pass_d  = (err_cnt == '0) && !hit;
                end else if (!start_stop && !v0_q && !s1_v_q) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                if (!start_stop) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        capture = v0_q && (state_d == RUN);
    end

    // Two-stage datapath: stage 1 latches operands, product and gold value;
    // stage 2 presents the registered write to the BRAM. Address and data
    // hold their last value while web is low.
    always_comb begin
        v0_d      = start_stop;
        s1_v_d    = capture;
        s1_addr_d = capture ? addra : s1_addr_q;
        s1_prod_d = capture ? product : s1_prod_q;
        s1_gold_d = capture ? ((2*DW)'(a) * (2*DW)'(b)) : s1_gold_q;
        web_d     = s1_v_q;
        addrb_d   = s1_v_q ? s1_addr_q : addrb_q;
        dinb_d    = s1_v_q ? s1_prod_q : dinb_q;
    end

    // State, pipeline and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            v0_q      <= 1'b0;
            s1_v_q    <= 1'b0;
            s1_addr_q <= '0;
            s1_prod_q <= '0;
            s1_gold_q <= '0;
            web_q     <= 1'b0;
            addrb_q   <= '0;
            dinb_q    <= '0;
            wr_cnt_q  <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            v0_q      <= v0_d;
            s1_v_q    <= s1_v_d;
            s1_addr_q <= s1_addr_d;
            s1_prod_q <= s1_prod_d;
            s1_gold_q <= s1_gold_d;
            web_q     <= web_d;
            addrb_q   <= addrb_d;
            dinb_q    <= dinb_d;
            wr_cnt_q  <= wr_cnt_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
        end
    end

    product_checker #(
        .DW(DW),
        .AW(AW)
    ) u_checker (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .s1_v    (s1_v_q),
        .s1_addr (s1_addr_q),
        .s1_prod (s1_prod_q),
        .s1_gold (s1_gold_q),
        .hit     (hit),
        .err_cnt (err_cnt),
        .err_addr(err_addr)
    );

endmodule

// File: tb/tb_product_writer.sv
// tb_product_writer
// Drives product_writer while playing the role of the operand controller,
// and compares every cycle against a transaction-level model: each operand
// loaded during a sweep (first DEPTH only) becomes one BRAM write two edges
// after its load, mismatches are judged with plain a*b arithmetic, and the
// sweep verdict follows from the count of writes and mismatches.
module tb_product_writer;

    import product_writer_pkg::*;

    localparam int PW = 2*DW;

    logic            clk = 1'b0;
    logic            rst;
    logic            start_stop;
    logic [DW-1:0]   a;
    logic [DW-1:0]   b;
    logic [AW-1:0]   addra;
    logic [PW-1:0]   product;
    logic            enb;
    logic            web;
    logic [AW-1:0]   addrb;
    logic [PW-1:0]   dinb;
    logic            done;
    logic            pass;
    logic [AW:0]     err_cnt;
    logic [AW-1:0]   err_addr;

    product_writer dut (
        .clk       (clk),
        .rst       (rst),
        .start_stop(start_stop),
        .a         (a),
        .b         (b),
        .addra     (addra),
        .product   (product),
        .enb       (enb),
        .web       (web),
        .addrb     (addrb),
        .dinb      (dinb),
        .done      (done),
        .pass      (pass),
        .err_cnt   (err_cnt),
        .err_addr  (err_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic [AW-1:0] addr;
        logic [PW-1:0] data;
        bit            bad;
    } wr_t;

    typedef enum {M_IDLE, M_RUN, M_DONE} mphase_e;

    wr_t           expQ[$];
    mphase_e       phase;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            loads, writes, expErrCnt, nextAddr;
    logic [AW-1:0] expErrAddr;
    logic          expDone, expPass, expWeb;
    logic [AW-1:0] expAddrb;
    logic [PW-1:0] expDinb;
    logic [DW-1:0] opA[DEPTH];
    logic [DW-1:0] opB[DEPTH];
    logic [PW-1:0] opP[DEPTH];

    function automatic logic [PW-1:0] gold(input logic [DW-1:0] x, input logic [DW-1:0] y);
        logic [PW-1:0] xx, yy;
        xx = PW'(x);
        yy = PW'(y);
        return xx * yy;
    endfunction

    task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        check("enb", PW'(enb), PW'(1'b1));
        check("web", PW'(web), PW'(expWeb));
        if (expWeb) begin
            check("addrb", PW'(addrb), PW'(expAddrb));
            check("dinb", dinb, expDinb);
        end
        check("err_cnt", PW'(err_cnt), PW'(expErrCnt));
        check("err_addr", PW'(err_addr), PW'(expErrAddr));
        check("done", PW'(done), PW'(expDone));
        check("pass", PW'(pass), PW'(expPass));
    endtask

    // Fill the operand table with random correct products.
    task automatic randomFill();
        for (int i = 0; i < DEPTH; i++) begin
            opA[i] = DW'($urandom);
            opB[i] = DW'($urandom);
            opP[i] = gold(opA[i], opB[i]);
        end
    endtask

    // One clock cycle: drive start_stop/rst, advance the model over the
    // edge, emulate the controller load, then check the DUT.
    task automatic applyStimulus(input logic ss, input logic r);
        wr_t w;
        start_stop = ss;
        rst = r;
        @(posedge clk);
        cyc++;
        #1;
        if (r) begin
            expQ.delete();
            phase = M_IDLE;
            loads = 0;
            writes = 0;
            expErrCnt = 0;
            expErrAddr = '0;
            expDone = 1'b0;
            expPass = 1'b0;
            expWeb = 1'b0;
        end else begin
            expWeb = 1'b0;
            if (expQ.size() > 0 && expQ[0].due == cyc) begin
                w = expQ.pop_front();
                expWeb = 1'b1;
                expAddrb = w.addr;
                expDinb = w.data;
                writes++;
                if (w.bad) begin
                    if (expErrCnt == 0) expErrAddr = w.addr;
                    if (expErrCnt < 15) expErrCnt++;
                end
                if (phase == M_RUN && writes == DEPTH) begin
                    phase = M_DONE;
                    expDone = 1'b1;
                    expPass = (expErrCnt == 0);
                end
            end
            if (ss) begin
                if (phase == M_IDLE) begin
                    phase = M_RUN;
                    loads = 0;
                    writes = 0;
                    expErrCnt = 0;
                    expErrAddr = '0;
                    expDone = 1'b0;
                    expPass = 1'b0;
                end
                addra = AW'(nextAddr);
                a = opA[nextAddr];
                b = opB[nextAddr];
                product = opP[nextAddr];
                if (phase == M_RUN && loads < DEPTH) begin
                    w.due = cyc + 2;
                    w.addr = addra;
                    w.data = product;
                    w.bad = (product != gold(a, b));
                    expQ.push_back(w);
                    loads++;
                end
                nextAddr = (nextAddr + 1) % DEPTH;
            end else if (phase == M_DONE || (phase == M_RUN && expQ.size() == 0)) begin
                phase = M_IDLE;
            end
        end
        checkOutput();
    endtask

    task automatic runSweep(input int hold, input int startAddr);
        nextAddr = startAddr;
        for (int i = 0; i < hold; i++) applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0);
    endtask

    initial begin
        a = '0;
        b = '0;
        addra = '0;
        product = '0;
        nextAddr = 0;
        randomFill();

        // Reset values
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        check("rst_addrb", PW'(addrb), '0);
        check("rst_dinb", dinb, '0);
        check("rst_state", PW'(dut.state_q), PW'(IDLE));
        applyStimulus(1'b0, 1'b0);

        // Single capture 3*5: written two edges after the load edge
        opA[0] = 16'd3; opB[0] = 16'd5; opP[0] = 32'd15;
        runSweep(1, 0);

        // Full sweep of FFFF*FFFF, extra loads past DEPTH are ignored
        for (int i = 0; i < DEPTH; i++) begin
            opA[i] = 16'hFFFF; opB[i] = 16'hFFFF; opP[i] = 32'hFFFE0001;
        end
        runSweep(8, 0);
        check("sweep1_done", PW'(done), PW'(1'b1));
        check("sweep1_pass", PW'(pass), PW'(1'b1));

        // Corrupted product at address 2
        randomFill();
        opA[2] = 16'd2; opB[2] = 16'd7; opP[2] = 32'h0;
        runSweep(8, 0);
        check("corrupt_err_addr", PW'(err_addr), PW'(3'd2));
        check("corrupt_pass", PW'(pass), PW'(1'b0));

        // Drop after three captures, with a mismatch to prove the restart clears it
        randomFill();
        opP[1] = ~opP[1];
        runSweep(3, 0);
        check("drop_state", PW'(dut.state_q), PW'(IDLE));
        check("drop_done", PW'(done), PW'(1'b0));
        randomFill();
        runSweep(7, 0);
        check("restart_pass", PW'(pass), PW'(1'b1));

        // Reset the cycle after a capture drops the in-flight write
        randomFill();
        nextAddr = 0;
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        check("midrst_state", PW'(dut.state_q), PW'(IDLE));
        check("midrst_addrb", PW'(addrb), '0);
        check("midrst_dinb", dinb, '0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);

        // Mismatch on the final write
        randomFill();
        opA[5] = 16'd1; opB[5] = 16'd1; opP[5] = 32'd2;
        runSweep(8, 0);
        check("last_err_addr", PW'(err_addr), PW'(3'd5));
        check("last_pass", PW'(pass), PW'(1'b0));

        // Random sweeps: random hold length, start address and corruption
        for (int s = 0; s < 6; s++) begin
            randomFill();
            for (int i = 0; i < DEPTH; i++) begin
                if ($urandom_range(0, 3) == 0) opP[i] = opP[i] ^ PW'($urandom_range(1, 255));
            end
            runSweep($urandom_range(1, 9), $urandom_range(0, DEPTH - 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/product_writer.md
Name: product_writer

Overview:
- Stage directly downstream of the operand-fetch controller and the combinational Dadda multiplier.
- Captures each product with its source operand address and writes it into a result BRAM (port B) at that same address.
- Self-checks every product against a behavioural a*b and reports pass/fail once a full sweep of DEPTH entries is written.

Parameters:
- DW, 16, operand width; product width is 2*DW.
- AW, 3, BRAM address width.
- DEPTH, 6, number of operand entries in one sweep (addresses 0..DEPTH-1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start_stop  input  1  run enable; same signal that gates the operand controller.
- a  input  DW  operand A from the controller's register.
- b  input  DW  operand B from the controller's register.
- addra  input  AW  address the current a/b were fetched from.
- product  input  2*DW  combinational Dadda output for the current a/b.
- enb  output  1  result BRAM enable, constant 1.
- web  output  1  result BRAM write strobe.
- addrb  output  AW  result BRAM write address.
- dinb  output  2*DW  result BRAM write data.
- done  output  1  sweep complete, sticky until IDLE.
- pass  output  1  valid when done=1; 1 if no mismatch in the sweep.
- err_cnt  output  AW+1  mismatches this sweep, saturating.
- err_addr  output  AW  address of the first mismatch.

Behaviour:
- Reset: web=0, addrb=0, dinb=0, done=0, pass=0, err_cnt=0, err_addr=0, state=IDLE, all valid flags 0. enb=1 always.
- v0 <= start_stop each cycle. The controller loads a/b/addra on the edge where start_stop=1, so inputs are valid in the cycle where v0=1.
- Stage 1, when v0=1 and state=RUN:
  - Register s1_addr<=addra, s1_prod<=product, s1_gold<=a*b (full 2*DW, unsigned).
  - s1_v<=1; otherwise s1_v<=0.
- Stage 2, when s1_v=1:
  - Drive web=1, addrb=s1_addr, dinb=s1_prod (registered outputs). web=0 otherwise.
  - If s1_prod!=s1_gold, err_cnt increments, saturating at 2^(AW+1)-1.
  - On the first mismatch of the sweep, err_addr<=s1_addr.
- Latency: web is high 3 clk edges after the edge that samples start_stop=1 (one edge each for controller load, stage 1, stage 2). Throughput is one write per cycle.
- wr_cnt counts stage-2 writes, 0..DEPTH, saturating.
- FSM:
  - IDLE: on start_stop=1, go to RUN and clear wr_cnt, err_cnt, err_addr, done, pass.
  - RUN: when the DEPTH-th write issues (wr_cnt reaches DEPTH on that edge), go to DONE with done<=1 and pass<=(err_cnt==0 including that write's check).
  - RUN, start_stop=0: stop capturing new stage-1 data, drain any in-flight s1_v write, then go to IDLE. done stays 0.
  - DONE: stage 1 no longer captures, so no further writes and the BRAM results stay frozen. On start_stop=0, go to IDLE; done and pass hold until the next IDLE→RUN transition.
- Wrap-around: addra wraps 5→0 upstream. Only the first DEPTH writes of a sweep count. No duplicate-address detection is required.
- Simultaneous events: rst overrides everything. Mismatch on the final write is included in pass. A start_stop drop on the same edge as the DEPTH-th write still completes the transition to DONE.
- Reset mid-operation: the in-flight write is dropped (web=0 on the next cycle). BRAM contents are not cleared.

Decomposition:
- Shared package holds DW, AW, DEPTH and the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
- One sub-module, product_checker: the registered compare, err_cnt and err_addr logic. It takes s1_v, s1_addr, s1_prod, s1_gold and a clear input.
- The pipeline and FSM stay in product_writer.

Test Plan:
- Reset, then start_stop=1 with a=3, b=5, addra=0 and product=15 → 3 edges later web=1, addrb=0, dinb=32'd15. err_cnt stays 0.
- Full sweep, addra 0..5 with a=16'hFFFF, b=16'hFFFF, product=32'hFFFE0001 at every address → six consecutive writes to 0..5, then done=1, pass=1, web=0.
- Corrupted product at addra=2 (32'h0) with a=2, b=7 → err_cnt=1, err_addr=2, sweep ends with done=1, pass=0; BRAM still receives 32'h0 at address 2.
- start_stop dropped after 3 captures → 3 writes complete, done=0, FSM in IDLE. Reasserting start_stop clears err_cnt and wr_cnt and starts a fresh sweep.
- rst asserted the cycle after a capture (s1_v=1) → web=0 next cycle, all outputs at reset values, state=IDLE.
- Mismatch on the 6th write (addra=5, a=1, b=1, product=2) → done=1, pass=0, err_addr=5 on the same edge.
